data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//   Per-pattern photon-count store for single-pixel imaging. Each rising edge of
//   DMD_sig (a new DMD mirror pattern) closes the previous pattern's exposure.
//   On that edge, the 16-bit count from the sibling counter_16bit is written
//   into the next free word. A host read mode (RD=1) then replays the stored
//   words in order on data_out, stepped by DMD_sig edges.
// PARAMETERS
//   DATA_W  16    width of each stored count word
//   DEPTH   1024  number of words; ADDR_W = $clog2(DEPTH)
// PORTS
//   clk      in   1       single system clock, all logic on posedge
//   rst      in   1       reset, asynchronous, active-low
//   RD       in   1       0 = acquire (write) mode, 1 = read-out mode; level, synchronous to clk
//   DMD_sig  in   1       pattern-change strobe from DMD, asynchronous; high pulse >= 1 clk period
//   data_in  in   DATA_W  photon count for the current pattern (from counter_16bit cnt)
//   data_out out  DATA_W  registered: last written word (RD=0) / current read word (RD=1)
// BEHAVIOUR
//   - Reset (rst=0, async): wr_cnt=0, rd_ptr=0, data_out=0, sync/edge FFs=0, RD_q=0.
//     Memory array is not cleared. Reset may assert mid-operation at any time.
//   - DMD_sig path: 2-FF synchroniser, then rising-edge detect -> 1-cycle strobe dmd_rise.
//     dmd_rise asserts on the 3rd clk posedge after DMD_sig rises. A falling edge has no effect.
//   - Acquire (RD=0 on the dmd_rise cycle):
//     - If wr_cnt<DEPTH: mem[wr_cnt]<=data_in (sampled on the dmd_rise cycle), wr_cnt<=wr_cnt+1,
//       data_out<=data_in, all on the same edge, so latency is 1 clk after dmd_rise.
//     - If wr_cnt==DEPTH (full): write dropped, wr_cnt saturates, data_out unchanged. No wrap.
//   - Read-out (RD=1):
//     - RD_q registers RD. On the cycle where RD=1 and RD_q=0, rd_ptr<=0 and data_out<=word(0).
//     - Each subsequent dmd_rise: rd_ptr<=rd_ptr+1, wrapping from DEPTH-1 to 0, and
//       data_out<=word(rd_ptr+1).
//     - word(a) = mem[a] if a<wr_cnt, else 16'h0000. Unwritten words always read as 0.
//     - No writes occur while RD=1. data_in is ignored.
//   - RD 1->0: return to acquire mode. wr_cnt is kept, so the next write appends.
//     data_out holds its value until the next write.
//   - Simultaneous events: RD is sampled on the same edge as dmd_rise and decides read vs write.
//     RD rising together with dmd_rise: the pointer reset wins (data_out=word(0)) and the
//     strobe is consumed.
//   - Widths: wr_cnt is ADDR_W+1 bits, so it can represent DEPTH. rd_ptr is ADDR_W bits.
//     Data is stored verbatim, with no saturation or arithmetic.
// STRUCTURE
//   - Shared package pc_pkg: DATA_W, DEPTH, ADDR_W localparams. This pkg also sets
//     counter_16bit's width.
//   - One sub-module: sync_rise_det, a 2-FF synchroniser plus rising-edge pulse with async
//     active-low reset. It is reusable for other asynchronous strobes.
//   - Memory array: inferred single-port RAM (write port, registered read).
//   - counter_16bit is a separate sibling block, not instantiated here.
// TESTING
//   - Reset: rst=0 mid-run -> data_out=0 at once; after release, the first write goes to address 0.
//   - Acquire: data_in=16'h0005, pulse DMD_sig -> mem[0]=5, data_out=5 four clks after the pulse.
//     Then data_in=16'h00A0, pulse -> mem[1]=0x00A0.
//   - Read-out: after 3 writes (5, 0xA0, 0xFFFF), set RD=1 -> data_out=5. Pulse -> 0xA0.
//     Pulse -> 0xFFFF. Pulse -> 0 (unwritten word).
//   - Full: DEPTH=4, 5 pulses in acquire mode -> the 5th write is dropped. Read-out shows
//     words 0..3, then wraps back to word 0.
//   - Strobe timing: a 1-clk-wide DMD_sig pulse -> exactly one write. A 10-clk pulse ->
//     exactly one write. A falling edge -> no write.
//   - Mode switch: RD 1->0, then pulse -> write appends at wr_cnt, and data_out shows data_in.

Source files
------------

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// Module : pc_pkg
// Shared sizing for the photon-count datapath (counter_16bit, data_memory).
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = $clog2(DEPTH);
endpackage

`default_nettype wire

// File: rtl/sync_rise_det.sv
// ---------------------------------------------------------------------------
// Module : sync_rise_det
// Two-flop synchroniser followed by a registered single-cycle rising-edge pulse.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], async_in};
      prev <= sync[1];
      rise <= sync[1] & ~prev;
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// Module : data_memory
// Per-pattern photon-count store: appends one word per DMD pattern edge,
// replays the stored words in order when RD is high.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_memory #(
  parameter int DATA_W = pc_pkg::DATA_W,
  parameter int DEPTH  = pc_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RD,
  input  logic              DMD_sig,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int                ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   FULL   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic              rd_q;
  logic              dmd_rise;
  logic              rd_start;
  logic              rd_step;
  logic              wr_en;

  sync_rise_det u_dmd_sync (
    .clk      (clk),
    .rst_n    (rst),
    .async_in (DMD_sig),
    .rise     (dmd_rise)
  );

  // Entering read mode takes priority and swallows a coincident strobe.
  assign rd_start = RD & ~rd_q;
  assign rd_step  = RD & rd_q & dmd_rise;
  assign wr_en    = dmd_rise & ~RD & (wr_cnt != FULL);

  assign rd_next = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
  assign rd_addr = rd_start ? '0 : rd_next;

  // Words at or beyond the write count have never been filled in this run.
  always_comb begin
    rd_word = '0;
    if ({1'b0, rd_addr} < wr_cnt) begin
      rd_word = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cnt[ADDR_W-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      rd_q     <= 1'b0;
      data_out <= '0;
    end else begin
      rd_q <= RD;
      if (rd_start) begin
        rd_ptr   <= '0;
        data_out <= rd_word;
      end else if (rd_step) begin
        rd_ptr   <= rd_next;
        data_out <= rd_word;
      end else if (wr_en) begin
        wr_cnt   <= wr_cnt + 1'b1;
        data_out <= data_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ---------------------------------------------------------------------------
// Module : tb_data_memory
// Self-checking bench for data_memory (DEPTH=4) against a pattern-level model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_memory;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              RD;
  logic              DMD_sig;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_cnt;
  int                m_ptr;
  logic [DATA_W-1:0] m_out;
  bit                m_rd;

  data_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .RD       (RD),
    .DMD_sig  (DMD_sig),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] m_word(int a);
    return (a < m_cnt) ? m_mem[a] : '0;
  endfunction

  task automatic check(string tag, logic [DATA_W-1:0] got, logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: data_out=%h expected=%h", tag, got, exp);
  endtask

  // One DMD pattern edge, held high for width clocks, then settled.
  task automatic pulse(int width, logic [DATA_W-1:0] d);
    data_in = d;
    @(negedge clk) DMD_sig = 1'b1;
    repeat (width) @(negedge clk);
    DMD_sig = 1'b0;
    repeat (6) @(negedge clk);
    if (!m_rd) begin
      if (m_cnt < DEPTH) begin
        m_mem[m_cnt] = d;
        m_cnt++;
        m_out = d;
      end
    end else begin
      m_ptr = (m_ptr + 1) % DEPTH;
      m_out = m_word(m_ptr);
    end
  endtask

  task automatic set_rd(bit v);
    @(negedge clk) RD = v;
    if (v && !m_rd) begin
      m_ptr = 0;
      m_out = m_word(0);
    end
    m_rd = v;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_async", data_out, '0);
    RD      = 1'b0;
    DMD_sig = 1'b0;
    m_cnt = 0;
    m_ptr = 0;
    m_out = '0;
    m_rd  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; RD = 1'b0; DMD_sig = 1'b0; data_in = '0;
    m_cnt = 0; m_ptr = 0; m_out = '0; m_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_init", data_out, '0);
    rst = 1'b1;
    @(negedge clk);

    // First write latency: the word appears on the fourth clock after DMD rises.
    data_in = 16'h0005;
    @(negedge clk) DMD_sig = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_3clk", data_out, 16'h0000);
    @(negedge clk);
    check("lat_4clk", data_out, 16'h0005);
    DMD_sig = 1'b0;
    repeat (6) @(negedge clk);
    m_mem[0] = 16'h0005; m_cnt = 1; m_out = 16'h0005;

    pulse(1, 16'h00A0);   check("wr_1clk", data_out, m_out);
    pulse(10, 16'hFFFF);  check("wr_10clk", data_out, m_out);

    set_rd(1'b1);         check("rd_word0", data_out, 16'h0005);
    pulse(2, 16'h1111);   check("rd_word1", data_out, 16'h00A0);
    pulse(2, 16'h2222);   check("rd_word2", data_out, 16'hFFFF);
    pulse(2, 16'h3333);   check("rd_unwritten", data_out, 16'h0000);
    pulse(2, 16'h4444);   check("rd_wrap", data_out, 16'h0005);

    set_rd(1'b0);         check("rd_exit_hold", data_out, 16'h0005);
    pulse(3, 16'h1234);   check("append", data_out, 16'h1234);
    pulse(3, 16'h7777);   check("full_drop", data_out, 16'h1234);

    set_rd(1'b1);         check("full_rd0", data_out, 16'h0005);
    pulse(1, '0);         check("full_rd1", data_out, 16'h00A0);
    pulse(1, '0);         check("full_rd2", data_out, 16'hFFFF);
    pulse(1, '0);         check("full_rd3", data_out, 16'h1234);
    pulse(1, '0);         check("full_wrap", data_out, 16'h0005);

    // RD rising on the strobe cycle: pointer reset wins, strobe consumed.
    do_reset();
    pulse(2, 16'h0011);
    pulse(2, 16'h0022);
    check("pre_sim", data_out, 16'h0022);
    @(negedge clk) DMD_sig = 1'b1;
    repeat (3) @(negedge clk);
    RD = 1'b1;
    repeat (2) @(negedge clk);
    DMD_sig = 1'b0;
    m_rd = 1'b1; m_ptr = 0; m_out = m_word(0);
    repeat (6) @(negedge clk);
    check("sim_rd_start", data_out, 16'h0011);
    pulse(2, '0);         check("sim_next", data_out, 16'h0022);

    // Randomised mix of writes, mode switches and mid-run resets.
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 11);
      if (op == 0) begin
        do_reset();
      end else if (op <= 3) begin
        set_rd(~m_rd);
      end else begin
        pulse($urandom_range(1, 10), DATA_W'($urandom));
      end
      check("rand", data_out, m_out);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
